// File: rtl/mcm_pack_param.sv
// mcm_pack_param: reads 3-byte groups from a frame RAM and packs each group into two
// DATA_W-bit words written to a strided group memory, one stream at a time.
module mcm_pack_param #(
    parameter int RD_AW       = 8,
    parameter int WR_AW       = 10,
    parameter int DATA_W      = 12,
    parameter int LSB_W       = 2,
    parameter int RD_LAT      = 2,
    parameter int N_STREAM    = 3,
    parameter int WPS         = 32,
    parameter int STRIDE      = 32,
    parameter int STREAM_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iDone,
    input  logic [7:0]        iData,
    output logic [RD_AW-1:0]  oRdAddr,
    output logic              oRdEn,
    input  logic              iBusy,
    output logic [DATA_W-1:0] oData,
    output logic [WR_AW-1:0]  oAddr,
    output logic              oWren,
    output logic              oBusy,
    output logic [3:0]        oStream,
    output logic              oFrameDone
);
    localparam int GROUPS   = WPS / 2;
    localparam int GW       = $clog2(GROUPS + 1);
    localparam int READ_LEN = 3 + RD_LAT;

    typedef enum logic [2:0] {IDLE, WAITMEM, READ, WRITE, CHECK, DONE} state_t;
    state_t state, nextState;

    logic [2:0]       busySync;
    logic             rear;
    logic [2:0]       cycCnt;
    logic [GW-1:0]    groupCnt;
    logic [7:0]       b0, b1;
    logic [LSB_W-1:0] b2Hi;
    logic [WR_AW-1:0] addrA, streamBase;
    logic             readLast, streamEnd, lastStream, clearCnt;

    // Shared byte supplies the low bits; the word is left-aligned and zero padded below.
    function automatic logic [DATA_W-1:0] packWord(input logic [7:0] hi, input logic [LSB_W-1:0] lo);
        logic [DATA_W-1:0] w;
        w = '0;
        w[DATA_W-1 -: 8+LSB_W] = {hi, lo};
        return w;
    endfunction

    assign rear       = busySync[2] & ~busySync[1];
    assign readLast   = (state == READ) && (cycCnt == 3'(READ_LEN - 1));
    assign streamEnd  = (groupCnt == GW'(GROUPS));
    assign lastStream = (oStream == 4'(N_STREAM - 1));
    assign clearCnt   = !iDone && ((state == WAITMEM) || (state == DONE));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        nextState = state;
        oRdEn     = 1'b0;
        oWren     = 1'b0;
        case (state)
            IDLE:    if (iDone) nextState = WAITMEM;
            WAITMEM: begin
                if (!iDone)    nextState = IDLE;
                else if (rear) nextState = READ;
            end
            READ: begin
                oRdEn = (cycCnt < 3'd3);
                if (readLast) nextState = WRITE;
            end
            WRITE: begin
                oWren = 1'b1;
                if (cycCnt != 3'd0) nextState = CHECK;
            end
            CHECK: begin
                if (!streamEnd)     nextState = READ;
                else if (lastStream) nextState = DONE;
                else                nextState = WAITMEM;
            end
            DONE:    if (!iDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busySync   <= '0;
            cycCnt     <= '0;
            groupCnt   <= '0;
            b0         <= '0;
            b1         <= '0;
            b2Hi       <= '0;
            addrA      <= '0;
            streamBase <= '0;
            oRdAddr    <= '0;
            oData      <= '0;
            oAddr      <= '0;
            oBusy      <= 1'b0;
            oStream    <= '0;
            oFrameDone <= 1'b0;
        end else begin
            busySync   <= {busySync[1:0], iBusy};
            oFrameDone <= 1'b0;
            if (clearCnt) begin
                cycCnt     <= '0;
                groupCnt   <= '0;
                addrA      <= '0;
                streamBase <= '0;
                oRdAddr    <= '0;
                oAddr      <= '0;
                oStream    <= '0;
            end else begin
                case (state)
                    WAITMEM: if (rear) begin
                        oBusy  <= 1'b1;
                        cycCnt <= '0;
                    end
                    READ: begin
                        cycCnt <= cycCnt + 3'd1;
                        if (oRdEn) oRdAddr <= oRdAddr + RD_AW'(1);
                        if (cycCnt == 3'(RD_LAT))     b0 <= iData;
                        if (cycCnt == 3'(RD_LAT + 1)) b1 <= iData;
                        // Third byte arrives on the last READ clock; w0 is formed straight from it.
                        if (readLast) begin
                            cycCnt <= '0;
                            b2Hi   <= iData[2*LSB_W-1:LSB_W];
                            oData  <= packWord(b0, iData[LSB_W-1:0]);
                            oAddr  <= addrA;
                        end
                    end
                    WRITE: begin
                        if (cycCnt == 3'd0) begin
                            cycCnt <= 3'd1;
                            oData  <= packWord(b1, b2Hi);
                            oAddr  <= addrA + WR_AW'(STRIDE);
                        end else begin
                            cycCnt   <= '0;
                            addrA    <= addrA + WR_AW'(2 * STRIDE);
                            groupCnt <= groupCnt + GW'(1);
                        end
                    end
                    CHECK: if (streamEnd) begin
                        oBusy      <= 1'b0;
                        oStream    <= oStream + 4'd1;
                        groupCnt   <= '0;
                        streamBase <= streamBase + WR_AW'(STREAM_STEP);
                        addrA      <= streamBase + WR_AW'(STREAM_STEP);
                        if (lastStream) oFrameDone <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
